// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: assembles 20-bit instructions, writes them from address 0, holds the CPU.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that must match before DONE.
module instr_mem_loader #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 20,
  parameter int DEPTH   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         byte_data,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_data,
  output logic               mem_wren,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_B0, S_B1, S_B2, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  function automatic logic [INSTR_W-1:0] pack_instr(input logic [3:0] b2_lo,
                                                    input logic [7:0] b1,
                                                    input logic [7:0] b0);
    return INSTR_W'({b2_lo, b1, b0});
  endfunction

  state_t             state_r, state_s;
  logic [15:0]        cnt_r, cnt_s;
  logic [15:0]        idx_r, idx_s;
  logic [15:0]        hdr_s;
  logic [7:0]         b0_r, b0_s, b1_r, b1_s;
  logic [INSTR_W-1:0] data_r, data_s;
  logic               accept_s;
  logic               ready_r, ready_s, wren_r, wren_s, hold_r, hold_s, done_r, done_s, err_r, err_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         sum_r, sum_s;
`endif

  // Next-state, datapath and next-output decode
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    b0_s     = b0_r;
    b1_s     = b1_r;
    data_s   = data_r;
`ifdef LOADER_CHECKSUM_EN
    sum_s    = sum_r;
`endif
    hdr_s    = {byte_data, cnt_r[7:0]};
    accept_s = byte_valid & ready_r;
    ready_s  = 1'b0;
    wren_s   = 1'b0;
    hold_s   = 1'b1;
    done_s   = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_s = S_HDR_LO;
          cnt_s   = 16'h0000;
          idx_s   = 16'h0000;
`ifdef LOADER_CHECKSUM_EN
          sum_s   = 8'h00;
`endif
        end else begin
          state_s = state_r;
        end
      end
      S_HDR_LO: begin
        if (accept_s) begin
          cnt_s   = {8'h00, byte_data};
          state_s = S_HDR_HI;
        end else begin
          state_s = state_r;
        end
      end
      S_HDR_HI: begin
        if (!accept_s) begin
          state_s = state_r;
        end else if (hdr_s == 16'h0000) begin
          cnt_s   = hdr_s;
          state_s = S_FIN;
        end else if ({1'b0, hdr_s} > DEPTH_L) begin
          cnt_s   = hdr_s;
          state_s = S_ERR;
        end else begin
          cnt_s   = hdr_s;
          state_s = S_B0;
        end
      end
      S_B0: begin
        if (accept_s) begin
          b0_s    = byte_data;
`ifdef LOADER_CHECKSUM_EN
          sum_s   = sum_r ^ byte_data;
`endif
          state_s = S_B1;
        end else begin
          state_s = state_r;
        end
      end
      S_B1: begin
        if (accept_s) begin
          b1_s    = byte_data;
`ifdef LOADER_CHECKSUM_EN
          sum_s   = sum_r ^ byte_data;
`endif
          state_s = S_B2;
        end else begin
          state_s = state_r;
        end
      end
      S_B2: begin
        if (!accept_s) begin
          state_s = state_r;
        end else if (byte_data[7:4] != 4'h0) begin
          state_s = S_ERR;
        end else begin
          data_s  = pack_instr(byte_data[3:0], b1_r, b0_r);
`ifdef LOADER_CHECKSUM_EN
          sum_s   = sum_r ^ byte_data;
`endif
          state_s = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_s = idx_r + 16'd1;
        if ((idx_r + 16'd1) == cnt_r) begin
          state_s = S_FIN;
        end else begin
          state_s = S_B0;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (!accept_s) begin
          state_s = state_r;
        end else if (byte_data == sum_r) begin
          state_s = S_DONE;
        end else begin
          state_s = S_ERR;
        end
      end
`endif
      default: state_s = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state register
    ready_s = (state_s inside {S_HDR_LO, S_HDR_HI, S_B0, S_B1, S_B2, S_CHK});
    wren_s  = (state_s == S_WRITE);
    hold_s  = (state_s != S_DONE);
    done_s  = (state_s == S_DONE);
    err_s   = (state_s == S_ERR);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 16'h0000;
      idx_r   <= 16'h0000;
      b0_r    <= 8'h00;
      b1_r    <= 8'h00;
      data_r  <= '0;
      ready_r <= 1'b0;
      wren_r  <= 1'b0;
      hold_r  <= 1'b1;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_r   <= 8'h00;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      b0_r    <= b0_s;
      b1_r    <= b1_s;
      data_r  <= data_s;
      ready_r <= ready_s;
      wren_r  <= wren_s;
      hold_r  <= hold_s;
      done_r  <= done_s;
      err_r   <= err_s;
`ifdef LOADER_CHECKSUM_EN
      sum_r   <= sum_s;
`endif
    end
  end

  assign byte_ready = ready_r;
  assign mem_addr   = ADDR_W'(idx_r);
  assign mem_data   = data_r;
  assign mem_wren   = wren_r;
  assign cpu_hold   = hold_r;
  assign done       = done_r;
  assign error      = err_r;

endmodule
